// File: rtl/text_buffer_writer_if.sv
// Character input stream between the character source and text_buffer_writer.
//   in_char  : character code offered by the source
//   in_valid : in_char is valid this cycle
//   in_ready : writer accepts in_char this cycle
// A byte is transferred on a rising clock edge where in_valid && in_ready.
interface text_buffer_writer_if #(
    parameter int CHAR_ID_LENGTH = 8
);
    logic [CHAR_ID_LENGTH-1:0] in_char;
    logic                      in_valid;
    logic                      in_ready;

    modport master (output in_char, output in_valid, input in_ready);
    modport slave  (input in_char, input in_valid, output in_ready);
endinterface

// File: rtl/text_buffer_writer.sv
// Owns the ROW_NUMBER x COL_NUMBER character-ID grid read by the pixel encoder.
// Bytes arriving on the stream interface are written at a hardware cursor;
// newline, carriage return and backspace are interpreted, a newline (or a
// wrap off the end of a line) blanks the new line, and clr_i blanks the
// whole screen.
//   clk          : system clock, all state changes on its rising edge
//   rst_n        : asynchronous active-low reset
//   bus          : character stream (slave side)
//   clr_i        : full-screen clear request, sampled every cycle
//   rd_row_i/col : pixel encoder read address
//   rd_char_o    : combinational grid[rd_row_i][rd_col_i]
//   cursor_*_o   : current cursor position
//   busy_o       : high while a line or full-screen clear is running
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | accepting characters at the cursor
// LINE_CLR | blanking row cursor_row, one column per cycle (cnt_q = column)
// FULL_CLR | blanking every cell, one per cycle (cnt_q = linear address)
module text_buffer_writer #(
    parameter int ROW_NUMBER     = 16,
    parameter int COL_NUMBER     = 32,
    parameter int ROW_BIT_LEN    = 4,
    parameter int COL_BIT_LEN    = 5,
    parameter int CHAR_ID_LENGTH = 8,
    parameter int TOTAL_CHAR     = 129,
    parameter logic [CHAR_ID_LENGTH-1:0] BLANK_ID = 8'h20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    text_buffer_writer_if.slave       bus,
    input  logic                      clr_i,
    input  logic [ROW_BIT_LEN-1:0]    rd_row_i,
    input  logic [COL_BIT_LEN-1:0]    rd_col_i,
    output logic [CHAR_ID_LENGTH-1:0] rd_char_o,
    output logic [ROW_BIT_LEN-1:0]    cursor_row_o,
    output logic [COL_BIT_LEN-1:0]    cursor_col_o,
    output logic                      busy_o
);
    localparam int ADDR_W = ROW_BIT_LEN + COL_BIT_LEN;
    localparam int CELLS  = ROW_NUMBER * COL_NUMBER;

    localparam logic [CHAR_ID_LENGTH-1:0] CH_BS    = CHAR_ID_LENGTH'(8'h08);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_NL    = CHAR_ID_LENGTH'(8'h0A);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_CR    = CHAR_ID_LENGTH'(8'h0D);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_SP    = CHAR_ID_LENGTH'(8'h20);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_LIMIT = CHAR_ID_LENGTH'(TOTAL_CHAR);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LINE_CLR = 2'd1,
        FULL_CLR = 2'd2
    } state_t;

    state_t                    state_q;
    logic [ADDR_W-1:0]         cnt_q;
    logic [ROW_BIT_LEN-1:0]    row_q;
    logic [COL_BIT_LEN-1:0]    col_q;
    logic                      busy_q;
    logic [CHAR_ID_LENGTH-1:0] grid_q [CELLS];

    logic                      xfer;
    logic                      printable;
    logic                      col_last;
    logic [ROW_BIT_LEN-1:0]    row_inc;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [CHAR_ID_LENGTH-1:0] wr_data;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ROW_BIT_LEN-1:0] r,
                                                  input logic [COL_BIT_LEN-1:0] c);
        return ADDR_W'(r) * ADDR_W'(COL_NUMBER) + ADDR_W'(c);
    endfunction

    // clr_i blocks acceptance in the same cycle it is seen.
    assign bus.in_ready = (state_q == IDLE) && !clr_i;
    assign xfer         = bus.in_valid && bus.in_ready;
    assign printable    = (bus.in_char >= CH_SP) && (bus.in_char < CH_LIMIT);
    assign col_last     = (col_q == COL_BIT_LEN'(COL_NUMBER - 1));
    // Explicit wrap so non-power-of-two row counts work.
    assign row_inc      = (row_q == ROW_BIT_LEN'(ROW_NUMBER - 1)) ? '0 : row_q + 1'b1;

    assign cursor_row_o = row_q;
    assign cursor_col_o = col_q;
    assign busy_o       = busy_q;
    assign rd_char_o    = grid_q[addr_of(rd_row_i, rd_col_i)];

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = BLANK_ID;
        if (!clr_i) begin
            case (state_q)
                FULL_CLR: begin
                    wr_en   = 1'b1;
                    wr_addr = cnt_q;
                end
                LINE_CLR: begin
                    wr_en   = 1'b1;
                    wr_addr = addr_of(row_q, cnt_q[COL_BIT_LEN-1:0]);
                end
                IDLE: begin
                    if (xfer && printable) begin
                        wr_en   = 1'b1;
                        wr_addr = addr_of(row_q, col_q);
                        wr_data = bus.in_char;
                    end else if (xfer && bus.in_char == CH_BS && col_q != '0) begin
                        wr_en   = 1'b1;
                        wr_addr = addr_of(row_q, col_q - 1'b1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Grid storage has no reset; FULL_CLR rewrites every cell after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            grid_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FULL_CLR;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
        end else if (clr_i) begin
            state_q <= FULL_CLR;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                FULL_CLR: begin
                    if (cnt_q == ADDR_W'(CELLS - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                LINE_CLR: begin
                    if (cnt_q == ADDR_W'(COL_NUMBER - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (xfer) begin
                        if ((printable && col_last) || bus.in_char == CH_NL) begin
                            col_q   <= '0;
                            row_q   <= row_inc;
                            cnt_q   <= '0;
                            state_q <= LINE_CLR;
                            busy_q  <= 1'b1;
                        end else if (printable) begin
                            col_q <= col_q + 1'b1;
                        end else if (bus.in_char == CH_CR) begin
                            col_q <= '0;
                        end else if (bus.in_char == CH_BS && col_q != '0) begin
                            col_q <= col_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule
